usbf_dma_arb: RTL and testbench

USBF_DMA_ARB -- requirements
Module: usbf_dma_arb

---
 rtl/usbf_dma_arb.sv | 124 ++++++++++++
 tb/tb_usbf_dma_arb.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usbf_dma_arb.sv
// Round-robin arbiter sharing one DMA channel among four endpoint register files.
// Each grant lasts up to BURST_MAX acks, followed by GAP idle cycles before re-arbitration.
module usbf_dma_arb #(
  parameter int BURST_MAX = 8,
  parameter int GAP       = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] ep_dma_req,
  input  logic [3:0] ep_en,
  output logic [3:0] ep_dma_ack,
  output logic       dma_req,
  input  logic       dma_ack,
  output logic [1:0] dma_sel,
  output logic       dma_busy,
  output logic       ack_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t     state_reg, state_next;
  logic [1:0] sel_reg, sel_next;
  logic [1:0] last_reg, last_next;
  logic [3:0] burst_reg, burst_next;
  logic [2:0] gap_reg, gap_next;
  logic       err_reg, err_next;

  logic [3:0] m;
  logic       cur_req;
  logic       fwd;
  logic       go_rel;
  logic [1:0] pick;
  logic [1:0] cand [4];
  logic [3:0] hit;

  assign m       = ep_dma_req & ep_en;
  assign cur_req = m[sel_reg];
  assign fwd     = dma_ack & (state_reg == GRANT) & cur_req;

  // Search order starts just after the previous owner and ends on it.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_cand
      assign cand[gi] = last_reg + 2'(gi + 1);
      assign hit[gi]  = m[cand[gi]];
    end
  endgenerate

  always_comb begin
    pick = last_reg;
    for (int k = 3; k >= 0; k--) begin
      if (hit[k]) pick = cand[k];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      sel_reg   <= 2'd0;
      last_reg  <= 2'd3;
      burst_reg <= 4'd0;
      gap_reg   <= 3'd0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      sel_reg   <= sel_next;
      last_reg  <= last_next;
      burst_reg <= burst_next;
      gap_reg   <= gap_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    last_next  = last_reg;
    burst_next = burst_reg;
    gap_next   = gap_reg;
    go_rel     = 1'b0;
    // Any ack that is not forwarded to an endpoint is stray.
    err_next   = dma_ack & ~fwd;
    case (state_reg)
      IDLE: begin
        if (m != 4'd0) begin
          state_next = GRANT;
          sel_next   = pick;
          burst_next = 4'd0;
        end
      end
      GRANT: begin
        if (!cur_req) begin
          go_rel = 1'b1;
        end else if (dma_ack) begin
          burst_next = burst_reg + 4'd1;
          if (burst_reg == 4'(BURST_MAX - 1)) go_rel = 1'b1;
        end
        if (go_rel) begin
          state_next = RELEASE;
          last_next  = sel_reg;
          gap_next   = 3'(GAP - 1);
        end
      end
      RELEASE: begin
        if (gap_reg == 3'd0) state_next = IDLE;
        else                 gap_next   = gap_reg - 3'd1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    dma_req    = (state_reg == GRANT) & cur_req;
    ep_dma_ack = fwd ? (4'b0001 << sel_reg) : 4'b0000;
    dma_sel    = sel_reg;
    dma_busy   = (state_reg != IDLE);
    ack_err    = err_reg;
  end

endmodule

// File: tb/tb_usbf_dma_arb.sv
// Bench for usbf_dma_arb: directed vector table, multi-cycle tenure sequences and
// randomized traffic against a tenure-level reference model, on two parameter sets.
module tb_usbf_dma_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] req_a, en_a, ep_ack_a, req_b, en_b, ep_ack_b;
  logic       ack_a, dreq_a, busy_a, err_a, ack_b, dreq_b, busy_b, err_b;
  logic [1:0] sel_a, sel_b;

  usbf_dma_arb u_a (
    .clk(clk), .rst(rst), .ep_dma_req(req_a), .ep_en(en_a), .ep_dma_ack(ep_ack_a),
    .dma_req(dreq_a), .dma_ack(ack_a), .dma_sel(sel_a), .dma_busy(busy_a), .ack_err(err_a)
  );

  usbf_dma_arb #(.BURST_MAX(1), .GAP(1)) u_b (
    .clk(clk), .rst(rst), .ep_dma_req(req_b), .ep_en(en_b), .ep_dma_ack(ep_ack_b),
    .dma_req(dreq_b), .dma_ack(ack_b), .dma_sel(sel_b), .dma_busy(busy_b), .ack_err(err_b)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int bm [2] = '{8, 1};
  int gp [2] = '{2, 1};

  // Reference model: owner of the channel, acks taken, cooldown cycles left.
  bit m_granted [2];
  int m_cool [2], m_owner [2], m_last [2], m_acks [2];
  bit m_err [2];

  logic [3:0] ap_req [2], ap_en [2], d_req [2], d_en [2];
  logic       ap_ack [2], d_ack [2];
  int         ack_mode [2];
  logic [8:0] obs [2];  // {dma_req, ep_dma_ack, dma_sel, dma_busy, ack_err}

  typedef struct {
    logic [3:0] req;
    logic [3:0] en;
    logic       ack;
    logic [8:0] exp;
  } vec_t;
  vec_t tbl [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void model_reset(int i);
    m_granted[i] = 0; m_cool[i] = 0; m_owner[i] = 0;
    m_last[i] = 3; m_acks[i] = 0; m_err[i] = 0;
  endfunction

  function automatic logic [8:0] expect_out(int i);
    logic [3:0] m  = ap_req[i] & ap_en[i];
    bit         on = m_granted[i] && m[m_owner[i]];
    logic [3:0] ea = (on && ap_ack[i]) ? 4'(1 << m_owner[i]) : 4'b0000;
    return {on, ea, 2'(m_owner[i]), (m_granted[i] || m_cool[i] > 0), m_err[i]};
  endfunction

  function automatic void model_step(int i);
    logic [3:0] m   = ap_req[i] & ap_en[i];
    bit         on  = m_granted[i] && m[m_owner[i]];
    bit         fin = 0;
    bit         found = 0;
    m_err[i] = ap_ack[i] && !on;
    if (m_granted[i]) begin
      if (!on) fin = 1;
      else if (ap_ack[i]) begin
        m_acks[i]++;
        if (m_acks[i] == bm[i]) fin = 1;
      end
      if (fin) begin
        m_granted[i] = 0; m_cool[i] = gp[i]; m_last[i] = m_owner[i];
      end
    end else if (m_cool[i] > 0) begin
      m_cool[i]--;
    end else if (m != 4'd0) begin
      for (int k = 1; k <= 4; k++) begin
        int c = (m_last[i] + k) % 4;
        if (!found && m[c]) begin m_owner[i] = c; found = 1; end
      end
      m_granted[i] = 1; m_acks[i] = 0;
    end
  endfunction

  function automatic logic [8:0] sample(int i);
    if (i == 0) return {dreq_a, ep_ack_a, sel_a, busy_a, err_a};
    return {dreq_b, ep_ack_b, sel_b, busy_b, err_b};
  endfunction

  task automatic apply_pins();
    req_a = ap_req[0]; en_a = ap_en[0]; ack_a = ap_ack[0];
    req_b = ap_req[1]; en_b = ap_en[1]; ack_b = ap_ack[1];
  endtask

  // One clock: drive, compare both DUTs with the model mid-cycle, advance the model.
  task automatic cycle();
    @(negedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) begin
      case (ack_mode[i])
        1:       ap_ack[i] = 1'b1;
        2:       ap_ack[i] = cyc[0];
        3:       ap_ack[i] = 1'($urandom_range(0, 1));
        default: ap_ack[i] = d_ack[i];
      endcase
      ap_req[i] = d_req[i];
      ap_en[i]  = d_en[i];
    end
    apply_pins();
    #2;
    for (int i = 0; i < 2; i++) begin
      obs[i] = sample(i);
      check($sformatf("model%0d", i), 32'(obs[i]), 32'(expect_out(i)));
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_step(i);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ap_req[i] = 4'hF; ap_en[i] = 4'hF; ap_ack[i] = 1'b1;
    end
    apply_pins();
    #2;
    check("reset_a", 32'(sample(0)), 32'd0);
    check("reset_b", 32'(sample(1)), 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      model_reset(i);
      ap_req[i] = 4'h0; ap_en[i] = 4'hF; ap_ack[i] = 1'b0;
      d_req[i] = 4'h0; d_en[i] = 4'hF; d_ack[i] = 1'b0; ack_mode[i] = 0;
    end
    apply_pins();
  endtask

  task automatic wait_grant(input int i);
    int n = 0;
    do begin
      cycle();
      n++;
    end while (!obs[i][8] && n < 40);
    check($sformatf("grant_wait%0d", i), 32'(obs[i][8]), 32'd1);
  endtask

  task automatic tenure(input int i, output int sel, output int acks, output int rel, output int idle);
    int n = 0;
    sel = int'(obs[i][3:2]); acks = 0; rel = 0; idle = 0;
    while (obs[i][8] && n < 100) begin
      if (obs[i][7:4] != 4'd0) acks++;
      cycle(); n++;
    end
    while (obs[i][1] && !obs[i][8] && n < 100) begin rel++; cycle(); n++; end
    while (!obs[i][1] && n < 100) begin idle++; cycle(); n++; end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL tenure_timeout inst %0d got %0d cycles want <100", i, n);
    end
    $display("tenure inst %0d sel %0d acks %0d release %0d idle %0d", i, sel, acks, rel, idle);
  endtask

  function automatic vec_t mk(logic [3:0] r, logic [3:0] e, logic a, logic q, logic [3:0] k,
                              logic [1:0] s, logic b, logic x);
    vec_t v;
    v.req = r; v.en = e; v.ack = a; v.exp = {q, k, s, b, x};
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sel, acks, rel, idle;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      model_reset(i);
      ap_req[i] = 0; ap_en[i] = 0; ap_ack[i] = 0;
      d_req[i] = 0; d_en[i] = 0; d_ack[i] = 0; ack_mode[i] = 0;
    end
    apply_pins();

    // Endpoint 2 alone (ep1 masked), drops after 3 acks, stray acks, enable pulled mid-grant.
    tbl[0]  = mk(4'b0000, 4'b1111, 1, 0, 4'b0000, 0, 0, 0);
    tbl[1]  = mk(4'b0110, 4'b1101, 0, 0, 4'b0000, 0, 0, 1);
    tbl[2]  = mk(4'b0110, 4'b1101, 1, 1, 4'b0100, 2, 1, 0);
    tbl[3]  = mk(4'b0110, 4'b1101, 1, 1, 4'b0100, 2, 1, 0);
    tbl[4]  = mk(4'b0110, 4'b1101, 0, 1, 4'b0000, 2, 1, 0);
    tbl[5]  = mk(4'b0110, 4'b1101, 1, 1, 4'b0100, 2, 1, 0);
    tbl[6]  = mk(4'b0010, 4'b1101, 1, 0, 4'b0000, 2, 1, 0);
    tbl[7]  = mk(4'b0110, 4'b1101, 1, 0, 4'b0000, 2, 1, 1);
    tbl[8]  = mk(4'b0110, 4'b1101, 0, 0, 4'b0000, 2, 1, 1);
    tbl[9]  = mk(4'b0110, 4'b1101, 0, 0, 4'b0000, 2, 0, 0);
    tbl[10] = mk(4'b0110, 4'b1101, 0, 1, 4'b0000, 2, 1, 0);
    tbl[11] = mk(4'b0110, 4'b1001, 1, 0, 4'b0000, 2, 1, 0);
    tbl[12] = mk(4'b0001, 4'b1111, 0, 0, 4'b0000, 2, 1, 1);
    tbl[13] = mk(4'b0001, 4'b1111, 0, 0, 4'b0000, 2, 1, 0);
    tbl[14] = mk(4'b0001, 4'b1111, 0, 0, 4'b0000, 2, 0, 0);
    tbl[15] = mk(4'b0001, 4'b1111, 1, 1, 4'b0001, 0, 1, 0);

    do_reset();
    for (int r = 0; r < 16; r++) begin
      d_req[0] = tbl[r].req; d_en[0] = tbl[r].en; d_ack[0] = tbl[r].ack;
      cycle();
      check($sformatf("row%0d", r), 32'(obs[0]), 32'(tbl[r].exp));
      $display("row %0d req %b en %b ack %b out %b", r, tbl[r].req, tbl[r].en, tbl[r].ack, obs[0]);
    end

    // Single requester, ack every other cycle.
    do_reset();
    d_req[0] = 4'b0001; ack_mode[0] = 2;
    wait_grant(0);
    tenure(0, sel, acks, rel, idle);
    check("solo_sel", sel, 0);
    check("solo_acks", acks, 8);
    check("solo_release", rel, 2);
    check("solo_idle", idle, 1);
    check("solo_regrant", 32'({obs[0][8], obs[0][3:2]}), 32'b100);

    // All four requesting, ack every cycle: round-robin order.
    do_reset();
    d_req[0] = 4'hF; ack_mode[0] = 1;
    wait_grant(0);
    for (int k = 0; k < 5; k++) begin
      tenure(0, sel, acks, rel, idle);
      check($sformatf("rr_sel%0d", k), sel, k % 4);
      check($sformatf("rr_acks%0d", k), acks, 8);
      check($sformatf("rr_gap%0d", k), rel + idle, 3);
    end

    // Reset in the middle of a grant with ack high; last pointer must reset too.
    do_reset();
    d_req[0] = 4'b1010; ack_mode[0] = 1;
    wait_grant(0);
    tenure(0, sel, acks, rel, idle);
    check("pre_rst_sel", sel, 1);
    cycle();
    rst = 1'b0;
    #1;
    check("rst_mid_grant", 32'({dreq_a, ep_ack_a, busy_a}), 32'd0);
    $display("reset mid-grant dma_req %b ep_dma_ack %b", dreq_a, ep_ack_a);
    @(posedge clk);
    #2;
    rst = 1'b1;
    model_reset(0);
    model_reset(1);
    wait_grant(0);
    check("post_rst_sel", 32'(obs[0][3:2]), 32'd1);

    // BURST_MAX=1, GAP=1 instance: alternating single-ack tenures.
    do_reset();
    d_req[1] = 4'b0011; ack_mode[1] = 1;
    wait_grant(1);
    for (int k = 0; k < 4; k++) begin
      tenure(1, sel, acks, rel, idle);
      check($sformatf("alt_sel%0d", k), sel, k % 2);
      check($sformatf("alt_acks%0d", k), acks, 1);
      check($sformatf("alt_idle%0d", k), idle, 1);
    end

    // Randomized traffic on both instances, model compared every cycle.
    do_reset();
    ack_mode[0] = 3; ack_mode[1] = 3;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(0, 3) == 0) d_req[i] = 4'($urandom);
        if ($urandom_range(0, 7) == 0) d_en[i] = ($urandom_range(0, 1) == 0) ? 4'($urandom) : 4'hF;
      end
      cycle();
    end
    $display("random phase done cycles 3000");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
